// File: rtl/v810_icache_assoc_if.sv
// V810 fetch bus: address/request from the master, data/acknowledge back.
// The cache is a slave on the EU side and a master toward memory.
interface v810_icache_assoc_if;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        req;
  logic        ack;

  modport master (
    output addr, req,
    input  rdata, ack
  );

  modport slave (
    input  addr, req,
    output rdata, ack
  );
endinterface

// File: rtl/v810_icache_assoc.sv
// Set-associative V810 instruction cache with round-robin victims and CHCW clear sequencer.
// Optional V810_ICACHE_PERF_EN adds HITCNT/MISSCNT performance counters.
module v810_icache_assoc #(
  parameter int WAYS = 2,
  parameter int IDXW = 7,
  parameter int SUBW = 1
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  output logic [31:0] CHCW,
  input  logic [31:0] CHCW_WD,
  input  logic        CHCW_WE,
  output logic        ICMAINT,
  v810_icache_assoc_if.slave  eu,
  v810_icache_assoc_if.master mem
`ifdef V810_ICACHE_PERF_EN
  ,
  output logic [31:0] HITCNT,
  output logic [31:0] MISSCNT
`endif
);

  localparam int SETS = 1 << IDXW;
  localparam int NSUB = 1 << SUBW;
  localparam int LO   = IDXW + SUBW + 2;
  localparam int TAGW = 32 - LO;
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef struct packed {
    logic [11:0] cen;
    logic [11:0] cec;
    logic [1:0]  rsv1;
    logic        icr;
    logic        icd;
    logic [1:0]  rsv0;
    logic        ice;
    logic        icc;
  } chcw_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    CLEAR
  } st_t;

  st_t   st_q, st_d;
  chcw_t cw_q, wd, wd_m;

  logic [TAGW-1:0] tag_q [WAYS][SETS];
  logic [NSUB-1:0] vld_q [WAYS][SETS];
  logic [31:0]     dat_q [WAYS][SETS][NSUB];
  logic [WW-1:0]   rr_q  [SETS];

  logic [SUBW-1:0] sub;
  logic [IDXW-1:0] set;
  logic [IDXW-1:0] cidx;
  logic [TAGW-1:0] tg;

  logic          hit_any, pm_any, inv_any;
  logic [WW-1:0] pm_way, inv_way, vic, rr_nxt;
  logic [31:0]   hword;
  logic          hit, stall, wr, abort, done;
  logic          go_fill, fill_wr, clr;
  logic [WW-1:0] vic_q;
  logic          vm_q, vr_q;
  logic          unused_ok;

  assign sub  = eu.addr[SUBW+1:2];
  assign set  = eu.addr[LO-1:SUBW+2];
  assign tg   = eu.addr[31:LO];
  assign cidx = cw_q.cen[IDXW-1:0];

  assign wd = CHCW_WD;
  always_comb begin
    wd_m      = '0;
    wd_m.cen  = wd.cen;
    wd_m.cec  = wd.cec;
    wd_m.icr  = wd.icr;
    wd_m.icd  = wd.icd;
    wd_m.ice  = wd.ice;
    wd_m.icc  = wd.icc;
  end

  // Descending scan so the lowest-numbered qualifying way wins.
  always_comb begin
    hit_any = 1'b0;
    pm_any  = 1'b0;
    inv_any = 1'b0;
    pm_way  = '0;
    inv_way = '0;
    hword   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (tag_q[w][set] == tg && vld_q[w][set][sub]) begin
        hit_any = 1'b1;
        hword   = dat_q[w][set][sub];
      end
      if (tag_q[w][set] == tg && |vld_q[w][set]) begin
        pm_any = 1'b1;
        pm_way = WW'(w);
      end
      if (vld_q[w][set] == '0) begin
        inv_any = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  assign vic = pm_any  ? pm_way :
               inv_any ? inv_way : rr_q[set];

  assign rr_nxt = (rr_q[set] == WW'(WAYS - 1)) ?
                  '0 : rr_q[set] + 1'b1;

  assign hit     = eu.req & hit_any;
  assign stall   = cw_q.icd | cw_q.icr;
  assign wr      = CE & CHCW_WE;
  assign abort   = wr & (~wd.ice | wd.icc);
  assign done    = (cw_q.cen >= 12'(SETS - 1)) |
                   (cw_q.cec <= 12'd1);
  assign go_fill = (st_q == IDLE) & cw_q.ice & ~stall &
                   eu.req & ~hit_any & ~abort;
  assign fill_wr = (st_q == FILL) & CE & mem.ack & ~abort;
  assign clr     = (st_q == CLEAR) & CE;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) st_q <= IDLE;
    else if (CE) st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (wr & wd.icc) st_d = CLEAR;
    else begin
      unique case (st_q)
        IDLE:    if (go_fill) st_d = FILL;
        FILL:    if (abort | mem.ack) st_d = IDLE;
        CLEAR:   if (wr | done) st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end
  end

  always_comb begin
    eu.ack   = 1'b0;
    eu.rdata = mem.rdata;
    mem.req  = 1'b0;
    if (!RES && st_q != CLEAR) begin
      if (!cw_q.ice) begin
        mem.req = eu.req;
        eu.ack  = mem.ack;
      end else if (st_q == FILL) begin
        mem.req = 1'b1;
      end else if (!stall && hit) begin
        eu.ack   = 1'b1;
        eu.rdata = hword;
      end
    end
  end

  assign mem.addr = eu.addr;
  assign CHCW     = cw_q;
  assign ICMAINT  = cw_q.icc | cw_q.icd | cw_q.icr;

  // A software write wins over the sequencer's own CEN/CEC step.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      cw_q <= '0;
    end else if (CE) begin
      if (CHCW_WE) begin
        cw_q <= wd_m;
      end else if (st_q == CLEAR) begin
        if (done) begin
          cw_q.cen <= '0;
          cw_q.cec <= '0;
          cw_q.icc <= 1'b0;
        end else begin
          cw_q.cen <= cw_q.cen + 12'd1;
          cw_q.cec <= cw_q.cec - 12'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      vic_q <= '0;
      vm_q  <= 1'b0;
      vr_q  <= 1'b0;
    end else if (CE && go_fill) begin
      vic_q <= vic;
      vm_q  <= pm_any;
      vr_q  <= ~pm_any & ~inv_any;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          tag_q[w][s] <= '0;
          vld_q[w][s] <= '0;
        end
      end
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (fill_wr) begin
      tag_q[vic_q][set] <= tg;
      vld_q[vic_q][set] <= (vm_q ? vld_q[vic_q][set] : '0) |
                           (NSUB'(1) << sub);
      if (vr_q) rr_q[set] <= rr_nxt;
    end else if (clr) begin
      for (int w = 0; w < WAYS; w++) vld_q[w][cidx] <= '0;
      rr_q[cidx] <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_wr) dat_q[vic_q][set][sub] <= mem.rdata;
  end

`ifdef V810_ICACHE_PERF_EN
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      HITCNT  <= '0;
      MISSCNT <= '0;
    end else if (CE) begin
      if (wr && wd.icc) begin
        HITCNT  <= '0;
        MISSCNT <= '0;
      end else begin
        if (eu.ack && cw_q.ice) HITCNT <= HITCNT + 32'd1;
        if (go_fill) MISSCNT <= MISSCNT + 32'd1;
      end
    end
  end
`endif

  assign unused_ok = ^{eu.addr[1:0], CHCW_WD[7:6], CHCW_WD[3:2]};

endmodule

// File: tb/tb_v810_icache_assoc.sv
// Directed bench for v810_icache_assoc (WAYS=2, IDXW=7, SUBW=1).
// Set = A[9:3], sub = A[2], tag = A[31:10].
module tb_v810_icache_assoc;
  logic        CLK = 1'b0;
  logic        RES = 1'b0;
  logic        CE = 1'b1;
  logic [31:0] CHCW;
  logic [31:0] CHCW_WD = '0;
  logic        CHCW_WE = 1'b0;
  logic        ICMAINT;
`ifdef V810_ICACHE_PERF_EN
  logic [31:0] HITCNT, MISSCNT;
`endif
  int nvec = 0;
  int nerr = 0;

  v810_icache_assoc_if eu ();
  v810_icache_assoc_if mem ();

  v810_icache_assoc dut (
    .CLK     (CLK),
    .RES     (RES),
    .CE      (CE),
    .CHCW    (CHCW),
    .CHCW_WD (CHCW_WD),
    .CHCW_WE (CHCW_WE),
    .ICMAINT (ICMAINT),
    .eu      (eu),
    .mem     (mem)
`ifdef V810_ICACHE_PERF_EN
    ,
    .HITCNT  (HITCNT),
    .MISSCNT (MISSCNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_chcw(input logic [31:0] v);
    CHCW_WD = v;
    CHCW_WE = 1'b1;
    tick();
    CHCW_WE = 1'b0;
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] d);
    eu.addr  = a;
    eu.req   = 1'b1;
    mem.ack  = 1'b0;
    tick();
    mem.rdata = d;
    mem.ack   = 1'b1;
    tick();
    mem.ack   = 1'b0;
    mem.rdata = 32'hBAD0_BAD0;
    tick();
    eu.req = 1'b0;
  endtask

  task automatic sample(input logic [31:0] a);
    eu.addr = a;
    eu.req  = 1'b1;
    @(negedge CLK);
  endtask

  task automatic drop();
    eu.req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1 RES = 1'b1;
    eu.addr   = 32'h100;
    eu.req    = 1'b1;
    mem.rdata = 32'h1234_5678;
    mem.ack   = 1'b1;
    @(negedge CLK);
    nvec++;
    if (mem.req !== 1'b0) begin
      nerr++; $display("FAIL rst_icireq got %b want 0", mem.req);
    end
    nvec++;
    if (eu.ack !== 1'b0) begin
      nerr++; $display("FAIL rst_euiack got %b want 0", eu.ack);
    end
    nvec++;
    if (eu.rdata !== 32'h1234_5678) begin
      nerr++; $display("FAIL rst_euid got %h want 12345678", eu.rdata);
    end
    nvec++;
    if (CHCW !== 32'h0 || ICMAINT !== 1'b0) begin
      nerr++; $display("FAIL rst_chcw got %h/%b want 0/0", CHCW, ICMAINT);
    end
    nvec++;
    if (mem.addr !== 32'h100) begin
      nerr++; $display("FAIL rst_icia got %h want 100", mem.addr);
    end
    eu.req  = 1'b0;
    mem.ack = 1'b0;
    @(posedge CLK);
    #1 RES = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    eu.addr   = 32'h100;
    eu.req    = 1'b1;
    mem.rdata = 32'hA5A5_0001;
    mem.ack   = 1'b1;
    @(negedge CLK);
    nvec++;
    if (eu.ack !== 1'b1 || eu.rdata !== 32'hA5A5_0001) begin
      nerr++;
      $display("FAIL t1_pass got %b/%h want 1/a5a50001", eu.ack, eu.rdata);
    end
    nvec++;
    if (mem.req !== 1'b1) begin
      nerr++; $display("FAIL t1_icireq got %b want 1", mem.req);
    end
    tick();
    eu.req  = 1'b0;
    mem.ack = 1'b0;
    tick();
    wr_chcw(32'h2);
    sample(32'h100);
    nvec++;
    if (eu.ack !== 1'b0 || mem.req !== 1'b0) begin
      nerr++;
      $display("FAIL t1_nowrite got %b/%b want 0/0", eu.ack, mem.req);
    end
    drop();
  endtask

  task automatic test_miss_hit();
    eu.addr   = 32'h400;
    eu.req    = 1'b1;
    mem.ack   = 1'b0;
    mem.rdata = 32'h0;
    @(negedge CLK);
    nvec++;
    if (eu.ack !== 1'b0) begin
      nerr++; $display("FAIL t2_miss_ack got %b want 0", eu.ack);
    end
    tick();
    @(negedge CLK);
    nvec++;
    if (mem.req !== 1'b1 || eu.ack !== 1'b0) begin
      nerr++;
      $display("FAIL t2_fill1 got req %b ack %b want 1/0", mem.req, eu.ack);
    end
    tick();
    mem.rdata = 32'hDEAD_0400;
    mem.ack   = 1'b1;
    @(negedge CLK);
    nvec++;
    if (mem.req !== 1'b1 || eu.ack !== 1'b0) begin
      nerr++;
      $display("FAIL t2_fill2 got req %b ack %b want 1/0", mem.req, eu.ack);
    end
    tick();
    mem.ack   = 1'b0;
    mem.rdata = 32'hBAD0_BAD0;
    @(negedge CLK);
    nvec++;
    if (eu.ack !== 1'b1 || eu.rdata !== 32'hDEAD_0400 ||
        mem.req !== 1'b0) begin
      nerr++;
      $display("FAIL t2_after got %b/%h/%b want 1/dead0400/0",
               eu.ack, eu.rdata, mem.req);
    end
    drop();
    sample(32'h400);
    nvec++;
    if (eu.ack !== 1'b1 || eu.rdata !== 32'hDEAD_0400 ||
        mem.req !== 1'b0) begin
      nerr++;
      $display("FAIL t2_rehit got %b/%h/%b want 1/dead0400/0",
               eu.ack, eu.rdata, mem.req);
    end
    drop();
  endtask

  task automatic test_subblock();
    fill(32'h404, 32'hDEAD_0404);
    sample(32'h404);
    nvec++;
    if (eu.ack !== 1'b1 || eu.rdata !== 32'hDEAD_0404) begin
      nerr++;
      $display("FAIL t3_sub1 got %b/%h want 1/dead0404", eu.ack, eu.rdata);
    end
    drop();
    sample(32'h400);
    nvec++;
    if (eu.ack !== 1'b1 || eu.rdata !== 32'hDEAD_0400) begin
      nerr++;
      $display("FAIL t3_sub0 got %b/%h want 1/dead0400", eu.ack, eu.rdata);
    end
    drop();
    fill(32'h800, 32'hDEAD_0800);
    sample(32'h404);
    nvec++;
    if (eu.ack !== 1'b1 || eu.rdata !== 32'hDEAD_0404) begin
      nerr++;
      $display("FAIL t3_sameway got %b/%h want 1/dead0404", eu.ack, eu.rdata);
    end
    drop();
  endtask

  task automatic test_assoc();
    RES = 1'b1;
    tick();
    RES = 1'b0;
    tick();
    wr_chcw(32'h2);
    fill(32'h000, 32'hA000_0000);
    fill(32'h400, 32'hA000_0400);
    fill(32'h800, 32'hA000_0800);
    sample(32'h800);
    nvec++;
    if (eu.ack !== 1'b1 || eu.rdata !== 32'hA000_0800) begin
      nerr++;
      $display("FAIL t4_hit800 got %b/%h want 1/a0000800", eu.ack, eu.rdata);
    end
    drop();
    sample(32'h400);
    nvec++;
    if (eu.ack !== 1'b1 || eu.rdata !== 32'hA000_0400) begin
      nerr++;
      $display("FAIL t4_hit400 got %b/%h want 1/a0000400", eu.ack, eu.rdata);
    end
    drop();
    sample(32'h000);
    nvec++;
    if (eu.ack !== 1'b0) begin
      nerr++; $display("FAIL t4_evict0 got %b want 0", eu.ack);
    end
    drop();
    fill(32'h000, 32'hA100_0000);
    sample(32'h400);
    nvec++;
    if (eu.ack !== 1'b0) begin
      nerr++; $display("FAIL t4_rr_evict400 got %b want 0", eu.ack);
    end
    drop();
    sample(32'h800);
    nvec++;
    if (eu.ack !== 1'b1 || eu.rdata !== 32'hA000_0800) begin
      nerr++;
      $display("FAIL t4_keep800 got %b/%h want 1/a0000800", eu.ack, eu.rdata);
    end
    drop();
  endtask

  task automatic test_clear();
    fill(32'h08, 32'hB000_0008);
    fill(32'h10, 32'hB000_0010);
    fill(32'h18, 32'hB000_0018);
    CHCW_WD = 32'h0000_0303;
    CHCW_WE = 1'b1;
    tick();
    CHCW_WE = 1'b0;
    CE = 1'b0;
    sample(32'h18);
    nvec++;
    if (ICMAINT !== 1'b1 || eu.ack !== 1'b0 || mem.req !== 1'b0) begin
      nerr++;
      $display("FAIL t5_inclear got %b/%b/%b want 1/0/0",
               ICMAINT, eu.ack, mem.req);
    end
    tick();
    CE = 1'b1;
    tick();
    CE = 1'b0;
    tick();
    CE = 1'b1;
    tick();
    @(negedge CLK);
    nvec++;
    if (CHCW !== 32'h0020_0103 || ICMAINT !== 1'b1) begin
      nerr++;
      $display("FAIL t5_mid got %h/%b want 00200103/1", CHCW, ICMAINT);
    end
    CE = 1'b0;
    tick();
    CE = 1'b1;
    tick();
    @(negedge CLK);
    nvec++;
    if (CHCW !== 32'h2 || ICMAINT !== 1'b0) begin
      nerr++;
      $display("FAIL t5_done got %h/%b want 00000002/0", CHCW, ICMAINT);
    end
    nvec++;
    if (eu.ack !== 1'b1 || eu.rdata !== 32'hB000_0018) begin
      nerr++;
      $display("FAIL t5_set3 got %b/%h want 1/b0000018", eu.ack, eu.rdata);
    end
    drop();
    sample(32'h10);
    nvec++;
    if (eu.ack !== 1'b0) begin
      nerr++; $display("FAIL t5_set2 got %b want 0", eu.ack);
    end
    drop();
    sample(32'h800);
    nvec++;
    if (eu.ack !== 1'b0) begin
      nerr++; $display("FAIL t5_set0 got %b want 0", eu.ack);
    end
    drop();
  endtask

  task automatic test_maint();
    fill(32'h30, 32'hC000_0030);
    wr_chcw(32'h12);
    sample(32'h30);
    nvec++;
    if (eu.ack !== 1'b0 || mem.req !== 1'b0 || ICMAINT !== 1'b1) begin
      nerr++;
      $display("FAIL icd_stall got %b/%b/%b want 0/0/1",
               eu.ack, mem.req, ICMAINT);
    end
    drop();
    wr_chcw(32'h2);
    sample(32'h30);
    nvec++;
    if (eu.ack !== 1'b1 || eu.rdata !== 32'hC000_0030) begin
      nerr++;
      $display("FAIL icd_resume got %b/%h want 1/c0000030", eu.ack, eu.rdata);
    end
    drop();
  endtask

  task automatic test_abort();
    eu.addr = 32'h20;
    eu.req  = 1'b1;
    tick();
    @(negedge CLK);
    nvec++;
    if (mem.req !== 1'b1) begin
      nerr++; $display("FAIL t6_infill got %b want 1", mem.req);
    end
    RES = 1'b1;
    #1;
    nvec++;
    if (mem.req !== 1'b0) begin
      nerr++; $display("FAIL t6_rst_req got %b want 0", mem.req);
    end
    eu.req = 1'b0;
    @(posedge CLK);
    #1 RES = 1'b0;
    tick();
    nvec++;
    if (CHCW !== 32'h0) begin
      nerr++; $display("FAIL t6_rst_chcw got %h want 0", CHCW);
    end
    wr_chcw(32'h2);
    sample(32'h30);
    nvec++;
    if (eu.ack !== 1'b0) begin
      nerr++; $display("FAIL t6_rst_inval got %b want 0", eu.ack);
    end
    drop();
    eu.addr = 32'h28;
    eu.req  = 1'b1;
    tick();
    mem.rdata = 32'hC0DE_0028;
    mem.ack   = 1'b1;
    CHCW_WD   = 32'h0;
    CHCW_WE   = 1'b1;
    tick();
    CHCW_WE = 1'b0;
    mem.ack = 1'b0;
    @(negedge CLK);
    nvec++;
    if (CHCW !== 32'h0 || eu.ack !== 1'b0 || mem.req !== 1'b1) begin
      nerr++;
      $display("FAIL t6_abort got %h/%b/%b want 0/0/1",
               CHCW, eu.ack, mem.req);
    end
    eu.req = 1'b0;
    tick();
    wr_chcw(32'h2);
    sample(32'h28);
    nvec++;
    if (eu.ack !== 1'b0) begin
      nerr++; $display("FAIL t6_nowrite got %b want 0", eu.ack);
    end
    drop();
  endtask

  initial begin
    eu.addr   = '0;
    eu.req    = 1'b0;
    mem.rdata = '0;
    mem.ack   = 1'b0;
    test_reset();
    test_passthrough();
    test_miss_hit();
    test_subblock();
    test_assoc();
    test_clear();
    test_maint();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
